// File: rtl/mem_dual_be.sv
// True dual-port RAM with byte-lane enables, 1/2-cycle read latency, selectable read-during-write
// and a post-reset clear sequencer. Define MEM_DUAL_BE_PARITY_EN to store and check per-lane even parity.
module mem_dual_be #(
  parameter int WIDTH    = 32,
  parameter int BYTE_W   = 8,
  parameter int DEPTH    = 256,
  parameter int LATENCY  = 1,
  parameter int RDW_MODE = 0,
  parameter int INIT     = 1,
  localparam int NB      = WIDTH / BYTE_W,
  localparam int ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic              init_busy,
  output logic              seq_state,
  input  logic [WIDTH-1:0]  data_0,
  input  logic [WIDTH-1:0]  data_1,
  input  logic [ADDR_W-1:0] address_0,
  input  logic [ADDR_W-1:0] address_1,
  input  logic              wren_0,
  input  logic              wren_1,
  input  logic [NB-1:0]     be_0,
  input  logic [NB-1:0]     be_1,
  input  logic              rden_0,
  input  logic              rden_1,
  output logic [WIDTH-1:0]  q_0,
  output logic [WIDTH-1:0]  q_1,
  output logic              q_valid_0,
  output logic              q_valid_1,
  output logic              collision,
  output logic              parity_err_0,
  output logic              parity_err_1
);

  // Read handshake: a request (rden_N=1 while not clearing) is accepted unconditionally;
  // exactly LATENCY edges later q_valid_N pulses for one cycle with q_N; q_N holds otherwise.
  localparam logic [ADDR_W:0]   DEPTH_V = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;
  state_t state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [WIDTH-1:0]  wdata    [2];
  logic [ADDR_W-1:0] addr     [2];
  logic [NB-1:0]     lane_wr  [2];
  logic              rd       [2];
  logic              in_range [2];
  logic [WIDTH-1:0]  rword    [2];
  logic              perr_now [2];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= (INIT != 0) ? CLEAR : READY;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      CLEAR: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == LAST) begin
          state_nxt = READY;
          cnt_nxt   = '0;
        end
      end
      default: ;
    endcase
  end

  assign init_busy = (state == CLEAR);
  assign seq_state = state;

  always_comb begin
    wdata[0] = data_0;
    wdata[1] = data_1;
    addr[0]  = address_0;
    addr[1]  = address_1;
    in_range[0] = ({1'b0, address_0} < DEPTH_V);
    in_range[1] = ({1'b0, address_1} < DEPTH_V);
    lane_wr[0] = (state == READY && wren_0 && in_range[0]) ? be_0 : '0;
    lane_wr[1] = (state == READY && wren_1 && in_range[1]) ? be_1 : '0;
    rd[0] = (state == READY) && rden_0;
    rd[1] = (state == READY) && rden_1;
  end

  // Port 1 is applied first so port 0 overrides it on lanes both ports enable.
  always_ff @(posedge clock) begin
    if (state == CLEAR) begin
      mem[cnt] <= '0;
    end else begin
      for (int p = 1; p >= 0; p--)
        for (int i = 0; i < NB; i++)
          if (lane_wr[p][i]) mem[addr[p]][i*BYTE_W +: BYTE_W] <= wdata[p][i*BYTE_W +: BYTE_W];
    end
  end

`ifdef MEM_DUAL_BE_PARITY_EN
  logic [NB-1:0] pmem [DEPTH];
  logic [NB-1:0] rpar [2];

  function automatic logic [NB-1:0] lane_par(input logic [WIDTH-1:0] w);
    for (int i = 0; i < NB; i++) lane_par[i] = ^w[i*BYTE_W +: BYTE_W];
  endfunction

  always_ff @(posedge clock) begin
    if (state == CLEAR) begin
      pmem[cnt] <= '0;
    end else begin
      for (int p = 1; p >= 0; p--)
        for (int i = 0; i < NB; i++)
          if (lane_wr[p][i]) pmem[addr[p]][i] <= ^wdata[p][i*BYTE_W +: BYTE_W];
    end
  end
`endif

  // Cross-port writes never forward; only the requesting port's own write merges in write-first mode.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rword[p] = in_range[p] ? mem[addr[p]] : '0;
`ifdef MEM_DUAL_BE_PARITY_EN
      rpar[p] = in_range[p] ? pmem[addr[p]] : '0;
`endif
      if (RDW_MODE == 0) begin
        for (int i = 0; i < NB; i++) begin
          if (lane_wr[p][i]) begin
            rword[p][i*BYTE_W +: BYTE_W] = wdata[p][i*BYTE_W +: BYTE_W];
            if (p == 1 && lane_wr[0][i] && addr[0] == addr[1])
              rword[p][i*BYTE_W +: BYTE_W] = wdata[0][i*BYTE_W +: BYTE_W];
`ifdef MEM_DUAL_BE_PARITY_EN
            rpar[p][i] = ^rword[p][i*BYTE_W +: BYTE_W];
`endif
          end
        end
      end
`ifdef MEM_DUAL_BE_PARITY_EN
      perr_now[p] = |(lane_par(rword[p]) ^ rpar[p]);
`else
      perr_now[p] = 1'b0;
`endif
    end
  end

  logic [WIDTH-1:0] s1_data [2], s2_data [2];
  logic             s1_valid[2], s2_valid[2];
  logic             s1_perr [2], s2_perr [2];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int p = 0; p < 2; p++) begin
        s1_data[p] <= '0; s1_valid[p] <= 1'b0; s1_perr[p] <= 1'b0;
        s2_data[p] <= '0; s2_valid[p] <= 1'b0; s2_perr[p] <= 1'b0;
      end
      collision <= 1'b0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        s1_valid[p] <= rd[p];
        s1_perr[p]  <= rd[p] && perr_now[p];
        if (rd[p]) s1_data[p] <= rword[p];
        s2_valid[p] <= s1_valid[p];
        s2_perr[p]  <= s1_perr[p];
        if (s1_valid[p]) s2_data[p] <= s1_data[p];
      end
      collision <= (addr[0] == addr[1]) && |(lane_wr[0] & lane_wr[1]);
    end
  end

  assign q_0          = (LATENCY == 2) ? s2_data[0]  : s1_data[0];
  assign q_1          = (LATENCY == 2) ? s2_data[1]  : s1_data[1];
  assign q_valid_0    = (LATENCY == 2) ? s2_valid[0] : s1_valid[0];
  assign q_valid_1    = (LATENCY == 2) ? s2_valid[1] : s1_valid[1];
  assign parity_err_0 = (LATENCY == 2) ? s2_perr[0]  : s1_perr[0];
  assign parity_err_1 = (LATENCY == 2) ? s2_perr[1]  : s1_perr[1];

endmodule

// File: doc/mem_dual_be.md
Name: mem_dual_be

Overview:
- Next-generation true dual-ported RAM that replaces the single-mode dual-ported memory.
- Adds per-lane byte enables, selectable read latency and read-during-write mode, deterministic cross-port collision handling, and a hardware clear sequencer that runs after reset.
- Used as the shared buffer between the crypto cores and the trace/capture logic.

Parameters:
- WIDTH, 32, data word width in bits; must be a multiple of BYTE_W.
- BYTE_W, 8, bits per byte-enable lane; NB = WIDTH/BYTE_W lanes.
- DEPTH, 256, number of words; ADDR_W = clog2(DEPTH), minimum 1.
- LATENCY, 1, read latency in cycles; legal values 1 or 2 (2 adds an output register stage).
- RDW_MODE, 0, same-port read-during-write: 0 = write-first (new merged word), 1 = read-first (old word).
- INIT, 1, 1 = clear sequencer zeroes all words after reset; 0 = no clear, ready immediately.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- init_busy  out  1  high while the clear sequencer runs.
- data_0 / data_1  in  WIDTH  write data, port 0 / port 1.
- address_0 / address_1  in  ADDR_W  word address.
- wren_0 / wren_1  in  1  write request.
- be_0 / be_1  in  NB  byte-lane enables; a write with be==0 is a no-op.
- rden_0 / rden_1  in  1  read request.
- q_0 / q_1  out  WIDTH  read data.
- q_valid_0 / q_valid_1  out  1  one-cycle pulse aligned with valid q_N.
- collision  out  1  one-cycle pulse: both ports wrote the same address with overlapping lanes.
- parity_err_0 / parity_err_1  out  1  parity error flag (see Optional Feature).

Behaviour:
- Reset (reset_n low): q_N=0, q_valid_N=0, collision=0, parity_err_N=0, pipeline cleared.
  - init_busy=1 if INIT=1, else 0.
  - Memory contents are not reset asynchronously.
- Sequencer FSM states: CLEAR, READY.
  - Leaving reset enters CLEAR if INIT=1, otherwise READY.
  - CLEAR writes all-zero to address cnt, where cnt runs 0..DEPTH-1, one word per cycle; moves to READY after cnt==DEPTH-1. Exactly DEPTH cycles of init_busy=1.
  - Reset asserted mid-CLEAR aborts; the clear restarts from 0 after release.
  - In CLEAR all port requests are ignored: no writes, no q_valid.
- Write (READY, wren_N=1): for each lane i with be_N[i]=1, mem[address_N] lane i <= data_N lane i. Other lanes are unchanged.
- Read (READY, rden_N=1): q_N and q_valid_N appear LATENCY cycles after the request edge. Back-to-back reads are fully pipelined, one per cycle. q_N holds its last value when q_valid_N=0.
- Same-port rden and wren in one cycle:
  - RDW_MODE=0: returns the merged post-write word.
  - RDW_MODE=1: returns the pre-write word.
- Cross-port, same address:
  - Both write: port 0 wins on overlapping lanes; port 1 lanes not enabled on port 0 are still written.
  - collision pulses one cycle after the edge only if (be_0 & be_1) != 0.
- Cross-port read of an address the other port writes in the same cycle: always returns the old word.
- Address arithmetic: addresses >= DEPTH (non-power-of-two DEPTH) are ignored for writes and return 0 on reads, with q_valid still asserted.

Optional Feature:
- Macro MEM_DUAL_BE_PARITY_EN.
- Defined:
  - Each lane stores one extra even-parity bit, computed on write (including sequencer zero writes).
  - On read, parity is checked per lane; parity_err_N is asserted together with q_valid_N if any lane mismatches.
  - Simulation may force stored bits to test this path.
- Not defined: no parity storage; parity_err_N is tied to 0.

Test Plan:
- INIT=1, DEPTH=16: release reset -> init_busy high exactly 16 cycles; then a read of every address returns 0 with q_valid_N.
- Write 0xAABBCCDD to addr 3 with be=1111, then 0x11223344 with be=0101 -> a read of addr 3 returns 0xAA22CC44.
- LATENCY=2: reads on port 1 of addrs 0,1,2 on consecutive cycles -> q_valid_1 high on cycles +2,+3,+4 with the matching data.
- Addr 5 holds 0; same-cycle write 0xFFFFFFFF plus read on port 0 -> RDW_MODE=0 returns 0xFFFFFFFF; RDW_MODE=1 returns 0.
- Addr 7 holds 0; both ports write addr 7 (port 0: 0x01010101 be=0011; port 1: 0x02020202 be=0110) -> collision pulses one cycle; addr 7 then reads 0x00020101.
- With MEM_DUAL_BE_PARITY_EN: write addr 9, force one stored data bit, read -> parity_err_0=1 with q_valid_0. Assert reset_n low mid-CLEAR -> the clear restarts and init_busy lasts a full DEPTH cycles.
